// File: rtl/phy_tx_arbiter_pkg.sv
// Shared types and constants for the PHY transmit arbiter.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2,
        IFG  = 2'd3
    } arb_state_e;

    localparam int ETH_MAX_FRAME_BYTES = 1518;
    localparam int ETH_DEFAULT_IFG     = 12;

    // Width of a source index; a single-source build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phy_tx_arbiter_if.sv
// Stream bundle between the frame sources, the arbiter and the PHY.
// The master modport is the arbiter's view, the slave modport the
// environment's view (sources plus PHY).
interface phy_tx_arbiter_if #(
    parameter int NUM_SRC = 2
);
    logic [8*NUM_SRC-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]   s_axis_tvalid;
    logic [NUM_SRC-1:0]   s_axis_tready;
    logic [NUM_SRC-1:0]   s_axis_tlast;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/phy_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the
// last granted index, wrapping, so the last winner has lowest priority.
module rr_arbiter
    import tx_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   last_grant,
    output logic                      any_req,
    output logic [idx_width(N)-1:0]   grant
);

    localparam int W = idx_width(N);

    int cand;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        any_req = |req;
        grant   = '0;
        cand    = 0;
        for (int i = N; i >= 1; i--) begin
            cand = (int'(last_grant) + i) % N;
            if (req[W'(cand)]) begin
                grant = W'(cand);
            end
        end
    end

endmodule

// File: rtl/phy_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one PHY transmit stream among
// NUM_SRC byte-wide frame sources. Adds an inter-frame gap after every
// frame and truncates frames longer than MAX_FRAME_BYTES (the tail is
// swallowed from the source). MAX_FRAME_BYTES must lie in 1..65535.
module phy_tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int IFG_CYCLES      = ETH_DEFAULT_IFG,
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    phy_tx_arbiter_if.master                bus,
    output logic [idx_width(NUM_SRC)-1:0]   grant_id,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            err_oversize
);

    localparam int GW    = idx_width(NUM_SRC);
    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [15:0]      LIMIT_IDX = 16'(MAX_FRAME_BYTES - 1);
    localparam logic [IFG_W-1:0] IFG_LAST  = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    // With no gap configured the end of a frame returns straight to arbitration.
    localparam arb_state_e AFTER_FRAME = (IFG_CYCLES == 0) ? IDLE : IFG;

    arb_state_e        state, state_nxt;
    logic [GW-1:0]     last_grant, last_grant_nxt, grant_nxt;
    logic [15:0]       byte_cnt, byte_cnt_nxt;
    logic [IFG_W-1:0]  ifg_cnt, ifg_cnt_nxt;

    logic              any_req;
    logic [GW-1:0]     rr_grant;
    logic [7:0]        src_data;
    logic              src_valid;
    logic              src_last;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req        (bus.s_axis_tvalid),
        .last_grant (last_grant),
        .any_req    (any_req),
        .grant      (rr_grant)
    );

    // Select the granted source's stream signals.
    always_comb begin
        src_data  = bus.s_axis_tdata[{grant_id, 3'b000} +: 8];
        src_valid = bus.s_axis_tvalid[grant_id];
        src_last  = bus.s_axis_tlast[grant_id];
    end

    assign busy = (state != IDLE);

    // State, grant and counter registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_SRC - 1);
            byte_cnt   <= '0;
            ifg_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
            byte_cnt   <= byte_cnt_nxt;
            ifg_cnt    <= ifg_cnt_nxt;
        end
    end

    // Next-state logic plus the passthrough, ready steering and event pulses.
    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant_id;
        last_grant_nxt     = last_grant;
        byte_cnt_nxt       = byte_cnt;
        ifg_cnt_nxt        = ifg_cnt;
        bus.s_axis_tready  = '0;
        bus.m_axis_tdata   = '0;
        bus.m_axis_tvalid  = 1'b0;
        bus.m_axis_tlast   = 1'b0;
        frame_done         = 1'b0;
        err_oversize       = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt      = rr_grant;
                    last_grant_nxt = rr_grant;
                    byte_cnt_nxt   = '0;
                    state_nxt      = FWD;
                end
            end

            FWD: begin
                bus.m_axis_tdata  = src_data;
                bus.m_axis_tvalid = src_valid;
                // Truncation marks the limit byte as last while it is presented,
                // keeping tlast stable across PHY back-pressure.
                bus.m_axis_tlast  = src_last || (byte_cnt == LIMIT_IDX);
                bus.s_axis_tready[grant_id] = bus.m_axis_tready;
                if (src_valid && bus.m_axis_tready) begin
                    if (byte_cnt != 16'hFFFF) begin
                        byte_cnt_nxt = byte_cnt + 16'd1;
                    end
                    if (src_last) begin
                        frame_done = 1'b1;
                        state_nxt  = AFTER_FRAME;
                    end else if (byte_cnt == LIMIT_IDX) begin
                        frame_done   = 1'b1;
                        err_oversize = 1'b1;
                        state_nxt    = DROP;
                    end
                end
            end

            DROP: begin
                bus.s_axis_tready[grant_id] = 1'b1;
                if (src_valid && src_last) begin
                    state_nxt = AFTER_FRAME;
                end
            end

            IFG: begin
                if (ifg_cnt == IFG_LAST) begin
                    ifg_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    ifg_cnt_nxt = ifg_cnt + IFG_W'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed bench for phy_tx_arbiter. Two instances: A with the Ethernet
// frame limit, B with a 16-byte limit; both use a 12-cycle gap. One set of
// source/PHY drivers is steered to the instance under test by 'sel'.
module tb_phy_tx_arbiter;
    import tx_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          sel;
    logic [1:0]  drv_valid;
    logic [1:0]  drv_last;
    logic [15:0] drv_data;
    logic        drv_ready;

    phy_tx_arbiter_if #(.NUM_SRC(2)) ifa ();
    phy_tx_arbiter_if #(.NUM_SRC(2)) ifb ();

    logic ga, gb, busy_a, busy_b, fd_a, fd_b, err_a, err_b;

    phy_tx_arbiter #(.NUM_SRC(2), .IFG_CYCLES(12), .MAX_FRAME_BYTES(1518)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .grant_id(ga),
        .busy(busy_a), .frame_done(fd_a), .err_oversize(err_a)
    );

    phy_tx_arbiter #(.NUM_SRC(2), .IFG_CYCLES(12), .MAX_FRAME_BYTES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .grant_id(gb),
        .busy(busy_b), .frame_done(fd_b), .err_oversize(err_b)
    );

    assign ifa.s_axis_tvalid = (sel == 0) ? drv_valid : 2'b00;
    assign ifa.s_axis_tlast  = (sel == 0) ? drv_last  : 2'b00;
    assign ifa.s_axis_tdata  = (sel == 0) ? drv_data  : 16'h0000;
    assign ifa.m_axis_tready = (sel == 0) ? drv_ready : 1'b0;
    assign ifb.s_axis_tvalid = (sel == 1) ? drv_valid : 2'b00;
    assign ifb.s_axis_tlast  = (sel == 1) ? drv_last  : 2'b00;
    assign ifb.s_axis_tdata  = (sel == 1) ? drv_data  : 16'h0000;
    assign ifb.m_axis_tready = (sel == 1) ? drv_ready : 1'b0;

    logic [7:0] o_data;
    logic       o_valid, o_last, o_busy, o_grant, o_fd, o_err;
    logic [1:0] o_sready;
    assign o_data   = (sel == 0) ? ifa.m_axis_tdata  : ifb.m_axis_tdata;
    assign o_valid  = (sel == 0) ? ifa.m_axis_tvalid : ifb.m_axis_tvalid;
    assign o_last   = (sel == 0) ? ifa.m_axis_tlast  : ifb.m_axis_tlast;
    assign o_sready = (sel == 0) ? ifa.s_axis_tready : ifb.s_axis_tready;
    assign o_busy   = (sel == 0) ? busy_a : busy_b;
    assign o_grant  = (sel == 0) ? ga : gb;
    assign o_fd     = (sel == 0) ? fd_a : fd_b;
    assign o_err    = (sel == 0) ? err_a : err_b;

    typedef struct { int c; int d; int l; int g; } beat_t;

    beat_t out_q[$];
    int    fd_q[$];
    int    err_q[$];
    int    busy_q[$];

    int len [2][4];
    int nfr [2];
    int fr  [2];
    int pos [2];
    int start [2];
    int cyc, rst_at, stall_used, mirror_bad;
    bit stall_en;
    logic [15:0] snap1;
    logic [1:0]  snap2;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_val(input int src, input int f, input int p);
        return 8'((src << 7) + (f << 5) + p);
    endfunction

    // Reset both DUTs and clear the source model; returns at posedge+1.
    task automatic start_test(input int s);
        sel = s;
        out_q.delete(); fd_q.delete(); err_q.delete(); busy_q.delete();
        for (int i = 0; i < 2; i++) begin
            nfr[i] = 0; fr[i] = 0; pos[i] = 0; start[i] = 0;
            for (int j = 0; j < 4; j++) len[i][j] = 1;
        end
        cyc = 0; rst_at = -1; stall_en = 0; stall_used = 0; mirror_bad = 0;
        snap1 = '1; snap2 = '1;
        drv_valid = '0; drv_last = '0; drv_data = '0; drv_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Run n cycles of source/PHY model; entered and left at posedge+1.
    task automatic run(input int n);
        logic [1:0] acc;
        int nb;
        for (int k = 0; k < n; k++) begin
            rst_n = (cyc != rst_at);
            for (int i = 0; i < 2; i++) begin
                if (fr[i] < nfr[i] && cyc >= start[i]) begin
                    drv_valid[i] = 1'b1;
                    drv_last[i]  = (pos[i] == len[i][fr[i]] - 1);
                    drv_data[8*i +: 8] = byte_val(i, fr[i], pos[i]);
                end else begin
                    drv_valid[i] = 1'b0;
                    drv_last[i]  = 1'b0;
                    drv_data[8*i +: 8] = 8'h00;
                end
            end
            drv_ready = 1'b1;
            #1;
            nb = out_q.size() + 1;
            if (stall_en && o_valid && nb >= 5 && nb <= 8 && stall_used < 3 * (nb - 4)) begin
                drv_ready = 1'b0;
                stall_used++;
            end
            #1;
            if (o_valid && drv_ready)
                out_q.push_back('{cyc, int'(o_data), int'(o_last), int'(o_grant)});
            if (o_fd)  fd_q.push_back(cyc);
            if (o_err) err_q.push_back(cyc);
            busy_q.push_back(int'(o_busy));
            if (stall_en) begin
                if (o_valid && (o_sready[1] !== drv_ready)) mirror_bad++;
                if (o_sready[0] !== 1'b0) mirror_bad++;
            end
            if (rst_at >= 0 && cyc == rst_at + 1)
                snap1 = {o_valid, o_last, o_data, o_sready, o_busy, o_grant, o_fd, o_err};
            if (rst_at >= 0 && cyc == rst_at + 2)
                snap2 = o_sready;
            acc = drv_valid & o_sready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    if (drv_last[i]) begin
                        fr[i]++;
                        pos[i] = 0;
                    end else begin
                        pos[i]++;
                    end
                end
            end
            cyc++;
        end
    endtask

    int bad;

    initial begin
        sel = 0;
        rst_n = 1'b0;
        drv_valid = '0; drv_last = '0; drv_data = '0; drv_ready = 1'b1;

        // Reset state on both instances
        start_test(0);
        #1;
        check("rst_a_tvalid", o_valid, 0);
        check("rst_a_tlast", o_last, 0);
        check("rst_a_tdata", o_data, 0);
        check("rst_a_sready", o_sready, 0);
        check("rst_a_busy", o_busy, 0);
        check("rst_a_grant", o_grant, 0);
        check("rst_a_flags", {o_fd, o_err}, 0);
        sel = 1;
        #1;
        check("rst_b_state", {o_valid, o_busy, o_sready, o_grant, o_fd, o_err}, 0);

        // Single 64-byte frame from source 0
        start_test(0);
        nfr[0] = 1; len[0][0] = 64;
        run(100);
        check("t1_count", out_q.size(), 64);
        check("t1_first_cyc", out_q[0].c, 1);
        bad = 0;
        for (int b = 0; b < 64; b++)
            if (out_q[b].c != 1 + b || out_q[b].d != b || out_q[b].l != int'(b == 63)) bad++;
        check("t1_stream", bad, 0);
        check("t1_done_n", fd_q.size(), 1);
        check("t1_done_cyc", fd_q[0], 64);
        check("t1_err_n", err_q.size(), 0);
        check("t1_busy_in_ifg", busy_q[76], 1);
        check("t1_busy_low", busy_q[77], 0);

        // Two sources, three 10-byte frames each
        start_test(0);
        nfr[0] = 3; nfr[1] = 3;
        for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) len[i][j] = 10;
        run(170);
        check("t2_count", out_q.size(), 60);
        bad = 0;
        for (int b = 0; b < 60; b++) begin
            if (out_q[b].c != 1 + 23 * (b / 10) + (b % 10) ||
                out_q[b].d != int'(byte_val((b / 10) % 2, (b / 10) / 2, b % 10)) ||
                out_q[b].l != int'((b % 10) == 9)) bad++;
        end
        check("t2_stream", bad, 0);
        for (int k = 0; k < 6; k++)
            check("t2_order", out_q[10 * k].g, k % 2);
        for (int k = 1; k < 6; k++)
            check("t2_gap", out_q[10 * k].c - out_q[10 * k - 1].c, 14);
        check("t2_done_n", fd_q.size(), 6);

        // Source 1 with PHY back-pressure on bytes 5..8
        start_test(0);
        nfr[1] = 1; len[1][0] = 20;
        stall_en = 1;
        run(45);
        check("t3_count", out_q.size(), 20);
        bad = 0;
        for (int b = 0; b < 20; b++)
            if (out_q[b].d != int'(byte_val(1, 0, b)) || out_q[b].l != int'(b == 19)) bad++;
        check("t3_stream", bad, 0);
        check("t3_grant", out_q[0].g, 1);
        check("t3_byte5_cyc", out_q[4].c, 8);
        check("t3_byte8_cyc", out_q[7].c, 20);
        check("t3_byte20_cyc", out_q[19].c, 32);
        check("t3_stalls", stall_used, 12);
        check("t3_ready_mirror", mirror_bad, 0);
        check("t3_done_cyc", fd_q[0], 32);

        // 25-byte frame against a 16-byte limit, then a normal frame
        start_test(1);
        nfr[0] = 2; len[0][0] = 25; len[0][1] = 5;
        run(60);
        check("t4_count", out_q.size(), 21);
        check("t4_trunc_last", out_q[15].l, 1);
        check("t4_trunc_data", out_q[15].d, 15);
        check("t4_trunc_cyc", out_q[15].c, 16);
        check("t4_pre_last", out_q[14].l, 0);
        check("t4_err_n", err_q.size(), 1);
        check("t4_err_cyc", err_q[0], 16);
        check("t4_done_n", fd_q.size(), 2);
        check("t4_done0_cyc", fd_q[0], 16);
        check("t4_busy_drop", busy_q[20], 1);
        check("t4_next_cyc", out_q[16].c, 39);
        check("t4_next_data", out_q[16].d, 32);
        check("t4_done1_cyc", fd_q[1], 43);
        check("t4_src_frames", fr[0], 2);

        // Frame exactly at the 16-byte limit
        start_test(1);
        nfr[0] = 2; len[0][0] = 16; len[0][1] = 5;
        run(50);
        check("t5_count", out_q.size(), 21);
        check("t5_err_n", err_q.size(), 0);
        check("t5_done_n", fd_q.size(), 2);
        check("t5_done0_cyc", fd_q[0], 16);
        check("t5_last", out_q[15].l, 1);
        check("t5_next_cyc", out_q[16].c, 30);
        check("t5_next_last", out_q[20].l, 1);

        // Reset at byte 7 of a source-1 frame; source 0 then requests
        start_test(0);
        nfr[1] = 1; len[1][0] = 20;
        nfr[0] = 1; len[0][0] = 4; start[0] = 8;
        rst_at = 7;
        run(20);
        check("t6_byte7_cyc", out_q[6].c, 7);
        check("t6_byte7_last", out_q[6].l, 0);
        check("t6_after_rst", snap1, 0);
        check("t6_sready", snap2, 2'b01);
        check("t6_next_cyc", out_q[7].c, 9);
        check("t6_next_data", out_q[7].d, 0);
        check("t6_next_grant", out_q[7].g, 0);
        check("t6_done_cyc", fd_q[0], 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
